mont_exp_ctrl: RTL and testbench

//  Sequencer for MSB-first square-and-multiply modular exponentiation in the Montgomery domain.

---
 rtl/mont_exp_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mont_exp_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mont_exp_ctrl.sv
// Purpose: sequences MSB-first square-and-multiply exponentiation in the Montgomery domain, one multiply at a time.
// Latency: sum over 2+L+popcount multiplies of (k+1) cycles each, plus one DONE cycle; start accepted in IDLE only.
// Backpressure: waits indefinitely on i_mont_done with operands held stable; start outside IDLE is ignored.
module mont_exp_ctrl #(
    parameter int WIDTH = 1024,
    parameter int EXP_W = 32,
    parameter int LEN_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_r2_mod_n,
    input  logic [WIDTH-1:0] i_r_mod_n,
    input  logic [EXP_W-1:0] i_e,
    input  logic [LEN_W-1:0] i_e_len,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_mont_start,
    output logic [WIDTH-1:0] o_mont_a,
    output logic [WIDTH-1:0] o_mont_b,
    input  logic             i_mont_done,
    input  logic [WIDTH-1:0] i_mont_result
);

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(EXP_W);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SQ,
        S_MUL,
        S_POST,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [EXP_W-1:0] r_e;
    logic [LEN_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;        // accumulator A, Montgomery domain
    logic [WIDTH-1:0] r_xt;       // x~ = x*R mod N
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_mont_a;
    logic [WIDTH-1:0] r_mont_b;
    logic             r_mont_start;
    logic             r_busy;
    logic             r_done;

    logic [LEN_W-1:0] w_len;
    logic [LEN_W-1:0] w_cnt_m1;
    logic [IDX_W-1:0] w_idx;
    logic             w_bit;
    logic             w_more;

    // Effective length clamp and current exponent bit (e[cnt-1]); cnt>=1 whenever w_bit is used.
    always_comb begin
        w_len    = (i_e_len > MAX_LEN) ? MAX_LEN : i_e_len;
        w_cnt_m1 = r_cnt - LEN_W'(1);
        w_idx    = w_cnt_m1[IDX_W-1:0];
        w_bit    = r_e[w_idx];
        w_more   = (r_cnt > LEN_W'(1));
    end

    // Sequencer: each multiply state issues operands on entry and advances on the multiplier's done pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_e          <= '0;
            r_cnt        <= '0;
            r_a          <= '0;
            r_xt         <= '0;
            r_result     <= '0;
            r_mont_a     <= '0;
            r_mont_b     <= '0;
            r_mont_start <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_mont_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_e          <= i_e;
                        r_cnt        <= w_len;
                        r_a          <= i_r_mod_n;
                        r_mont_a     <= i_x;
                        r_mont_b     <= i_r2_mod_n;
                        r_mont_start <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_PRE;
                    end
                end
                S_PRE: begin
                    if (i_mont_done) begin
                        r_xt         <= i_mont_result;
                        r_mont_a     <= r_a;
                        r_mont_start <= 1'b1;
                        if (r_cnt != '0) begin
                            r_mont_b <= r_a;
                            r_state  <= S_SQ;
                        end else begin
                            r_mont_b <= ONE;
                            r_state  <= S_POST;
                        end
                    end
                end
                S_SQ: begin
                    if (i_mont_done) begin
                        r_a          <= i_mont_result;
                        r_mont_a     <= i_mont_result;
                        r_mont_start <= 1'b1;
                        if (w_bit) begin
                            r_mont_b <= r_xt;
                            r_state  <= S_MUL;
                        end else begin
                            r_cnt <= w_cnt_m1;
                            if (w_more) begin
                                r_mont_b <= i_mont_result;
                                r_state  <= S_SQ;
                            end else begin
                                r_mont_b <= ONE;
                                r_state  <= S_POST;
                            end
                        end
                    end
                end
                S_MUL: begin
                    if (i_mont_done) begin
                        r_a          <= i_mont_result;
                        r_mont_a     <= i_mont_result;
                        r_mont_start <= 1'b1;
                        r_cnt        <= w_cnt_m1;
                        if (w_more) begin
                            r_mont_b <= i_mont_result;
                            r_state  <= S_SQ;
                        end else begin
                            r_mont_b <= ONE;
                            r_state  <= S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (i_mont_done) begin
                        r_result <= i_mont_result;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_result     = r_result;
    assign o_mont_start = r_mont_start;
    assign o_mont_a     = r_mont_a;
    assign o_mont_b     = r_mont_b;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: WIDTH=8, N=13, R=256, behavioural Montgomery multiplier with programmable latency.
// Expected results come from plain modular exponentiation and the square-and-multiply operation list.
// Summary line reports total comparisons and errors.
module tb_mont_exp_ctrl;

    localparam int WIDTH = 8;
    localparam int EXP_W = 32;
    localparam int LEN_W = 6;
    localparam int N     = 13;
    localparam int RR    = 256;
    localparam int RMOD  = 9;
    localparam int R2MOD = 3;

    logic             clk;
    logic             resetn;
    logic             i_start;
    logic [WIDTH-1:0] i_x;
    logic [WIDTH-1:0] i_r2_mod_n;
    logic [WIDTH-1:0] i_r_mod_n;
    logic [EXP_W-1:0] i_e;
    logic [LEN_W-1:0] i_e_len;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_result;
    logic             o_mont_start;
    logic [WIDTH-1:0] o_mont_a;
    logic [WIDTH-1:0] o_mont_b;
    logic             mont_done;
    logic [WIDTH-1:0] mont_result;

    int checks = 0;
    int errors = 0;

    // multiplier model state
    int   lat = 3;
    int   rem = 0;
    logic done_reg = 1'b0;
    logic inj = 1'b0;

    // monitor state
    int q_a[$];
    int q_b[$];
    int done_cnt = 0;
    int busy_cnt = 0;

    mont_exp_ctrl #(.WIDTH(WIDTH), .EXP_W(EXP_W), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .i_start      (i_start),
        .i_x          (i_x),
        .i_r2_mod_n   (i_r2_mod_n),
        .i_r_mod_n    (i_r_mod_n),
        .i_e          (i_e),
        .i_e_len      (i_e_len),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_result     (o_result),
        .o_mont_start (o_mont_start),
        .o_mont_a     (o_mont_a),
        .o_mont_b     (o_mont_b),
        .i_mont_done  (mont_done),
        .i_mont_result(mont_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rinv();
        for (int r = 1; r < N; r++) if (((RR % N) * r) % N == 1) return r;
        return 0;
    endfunction

    function automatic int mont(input int a, input int b);
        return ((a % N) * (b % N) * rinv()) % N;
    endfunction

    function automatic int modpow(input int x, input logic [31:0] e, input int len);
        int res = 1;
        int b   = x % N;
        for (int i = 0; i < len; i++) begin
            if (e[i]) res = (res * b) % N;
            b = (b * b) % N;
        end
        return res;
    endfunction

    function automatic int eff_len(input int len);
        return (len > EXP_W) ? EXP_W : len;
    endfunction

    function automatic int nmul(input logic [31:0] e, input int len);
        int n = 2 + len;
        for (int i = 0; i < len; i++) if (e[i]) n++;
        return n;
    endfunction

    assign mont_result = WIDTH'(mont(int'(o_mont_a), int'(o_mont_b)));
    assign mont_done   = inj | ((lat == 0) ? o_mont_start : done_reg);

    // Multiplier latency model: done asserted lat cycles after the entry cycle.
    always @(negedge clk) begin
        if (o_mont_start) begin
            rem      = lat;
            done_reg = 1'b0;
        end else if (rem > 0) begin
            rem      = rem - 1;
            done_reg = (rem == 0);
        end else begin
            done_reg = 1'b0;
        end
    end

    // Observation of issued operands, done pulses and busy cycles.
    always @(negedge clk) begin
        if (o_mont_start) begin
            q_a.push_back(int'(o_mont_a));
            q_b.push_back(int'(o_mont_b));
        end
        if (o_done) done_cnt++;
        if (o_busy) busy_cnt++;
    end

    task automatic clear_mon();
        q_a.delete();
        q_b.delete();
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    // Launch one exponentiation and wait (bounded) for its done pulse.
    task automatic do_run(input int x, input logic [31:0] e, input int len, input int latv,
                          input bit hold_start);
        bit seen = 0;
        @(posedge clk); #1;
        lat = latv;
        clear_mon();
        i_x = WIDTH'(x); i_e = e; i_e_len = LEN_W'(len);
        i_r2_mod_n = WIDTH'(R2MOD); i_r_mod_n = WIDTH'(RMOD);
        i_start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) i_start = 1'b0;
        i_x = '0; i_e = '0; i_e_len = '0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            if (o_done) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL run_timeout: done=0 required done=1 (x=%0d e=%h len=%0d)", x, e, len);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; i_start = 1'b0; inj = 1'b0;
        i_x = '0; i_e = '0; i_e_len = '0; i_r2_mod_n = '0; i_r_mod_n = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", o_done); end
        checks++; if (o_mont_start !== 1'b0) begin errors++; $display("FAIL reset_mstart: got %b want 0", o_mont_start); end
        checks++; if (o_mont_a !== '0) begin errors++; $display("FAIL reset_mont_a: got %0d want 0", o_mont_a); end
        checks++; if (o_mont_b !== '0) begin errors++; $display("FAIL reset_mont_b: got %0d want 0", o_mont_b); end
        checks++; if (o_result !== '0) begin errors++; $display("FAIL reset_result: got %0d want 0", o_result); end
        resetn = 1'b1;
    endtask

    task automatic test_t1_order();
        int ea[$];
        int eb[$];
        int xt;
        int a;
        logic [31:0] e = 32'b1011;
        do_run(5, e, 4, 3, 0);
        repeat (3) @(posedge clk);
        #1;
        // expected operand list straight from the square-and-multiply recipe
        xt = mont(5, R2MOD);
        a  = RMOD;
        ea.push_back(5); eb.push_back(R2MOD);
        for (int i = 3; i >= 0; i--) begin
            ea.push_back(a); eb.push_back(a);
            a = mont(a, a);
            if (e[i]) begin
                ea.push_back(a); eb.push_back(xt);
                a = mont(a, xt);
            end
        end
        ea.push_back(a); eb.push_back(1);
        checks++;
        if (q_a.size() !== 9) begin errors++; $display("FAIL t1_pulses: got %0d want 9", q_a.size()); end
        for (int i = 0; i < 9 && i < q_a.size(); i++) begin
            checks++;
            if (q_a[i] !== ea[i] || q_b[i] !== eb[i]) begin
                errors++;
                $display("FAIL t1_op%0d: got (%0d,%0d) want (%0d,%0d)", i, q_a[i], q_b[i], ea[i], eb[i]);
            end
        end
        checks++; if (o_result !== 8'd8) begin errors++; $display("FAIL t1_result: got %0d want 8", o_result); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL t1_done_pulses: got %0d want 1", done_cnt); end
        checks++; if (busy_cnt !== 9 * 4 + 1) begin errors++; $display("FAIL t1_busy_cycles: got %0d want %0d", busy_cnt, 9 * 4 + 1); end
    endtask

    task automatic test_elen0();
        do_run(5, 32'hFFFF_FFFF, 0, 3, 0);
        checks++; if (q_a.size() !== 2) begin errors++; $display("FAIL elen0_pulses: got %0d want 2", q_a.size()); end
        checks++; if (o_result !== 8'd1) begin errors++; $display("FAIL elen0_result: got %0d want 1", o_result); end
    endtask

    task automatic test_upper_bits();
        do_run(7, 32'hFFFF_FF00, 8, 2, 0);
        checks++; if (q_a.size() !== 10) begin errors++; $display("FAIL upper_pulses: got %0d want 10", q_a.size()); end
        checks++; if (o_result !== 8'd1) begin errors++; $display("FAIL upper_result: got %0d want 1", o_result); end
    endtask

    task automatic test_start_held();
        int bad = 0;
        // stray multiplier completions while idle must not move the block
        @(posedge clk); #1;
        inj = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (o_busy !== 1'b0 || o_mont_start !== 1'b0) bad++;
        end
        inj = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL idle_done_ignored: got %0d active cycles want 0", bad); end
        do_run(5, 32'b1011, 4, 1, 1);
        checks++; if (q_a.size() !== 9) begin errors++; $display("FAIL held_pulses: got %0d want 9", q_a.size()); end
        checks++; if (o_result !== 8'd8) begin errors++; $display("FAIL held_result: got %0d want 8", o_result); end
        // inputs were zeroed after the first acceptance, so the rerun is x=0,e_len=0
        @(posedge clk); #1;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL held_restart: busy=%b want 1", o_busy); end
        i_start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checks++; if (o_result !== 8'd1) begin errors++; $display("FAIL held_rerun_result: got %0d want 1", o_result); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int bad  = 0;
        @(posedge clk); #1;
        lat = 3;
        i_x = 8'd5; i_e = 32'b1011; i_e_len = 6'd4;
        i_r2_mod_n = WIDTH'(R2MOD); i_r_mod_n = WIDTH'(RMOD);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int c = 0; c < 200 && seen < 4; c++) begin
            @(negedge clk);
            if (o_mont_start) seen++;
        end
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        checks++;
        if ({o_busy, o_done, o_mont_start} !== 3'b000 || o_mont_a !== '0 || o_mont_b !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: busy=%b done=%b ms=%b a=%0d b=%0d want all 0",
                     o_busy, o_done, o_mont_start, o_mont_a, o_mont_b);
        end
        repeat (6) begin
            @(negedge clk);
            if (o_busy !== 1'b0 || o_mont_start !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL midreset_stale_done: got %0d active cycles want 0", bad); end
        do_run(5, 32'b1011, 4, 3, 0);
        checks++; if (q_a.size() !== 9) begin errors++; $display("FAIL midreset_rerun_pulses: got %0d want 9", q_a.size()); end
        checks++; if (o_result !== 8'd8) begin errors++; $display("FAIL midreset_rerun_result: got %0d want 8", o_result); end
    endtask

    task automatic test_latency0();
        do_run(5, 32'b1011, 4, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (q_a.size() !== 9) begin errors++; $display("FAIL lat0_pulses: got %0d want 9", q_a.size()); end
        checks++; if (o_result !== 8'd8) begin errors++; $display("FAIL lat0_result: got %0d want 8", o_result); end
        checks++; if (busy_cnt !== 10) begin errors++; $display("FAIL lat0_busy_cycles: got %0d want 10", busy_cnt); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            int x    = $urandom_range(N - 1, 0);
            logic [31:0] e = $urandom;
            int len  = $urandom_range(40, 0);
            int lv   = $urandom_range(4, 0);
            int l    = eff_len(len);
            int want = modpow(x, e, l);
            int nm   = nmul(e, l);
            do_run(x, e, len, lv, 0);
            repeat (2) @(posedge clk);
            #1;
            checks++;
            if (int'(o_result) !== want) begin
                errors++;
                $display("FAIL rand%0d_result: got %0d want %0d (x=%0d e=%h len=%0d)", t, o_result, want, x, e, len);
            end
            checks++;
            if (q_a.size() !== nm) begin
                errors++;
                $display("FAIL rand%0d_pulses: got %0d want %0d", t, q_a.size(), nm);
            end
            checks++;
            if (busy_cnt !== nm * (lv + 1) + 1 || done_cnt !== 1) begin
                errors++;
                $display("FAIL rand%0d_timing: busy=%0d done=%0d want busy=%0d done=1", t, busy_cnt, done_cnt, nm * (lv + 1) + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_t1_order();
        test_elen0();
        test_upper_bits();
        test_start_held();
        test_reset_mid();
        test_latency0();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
